// File: rtl/dd_scan_driver.sv
// dd_scan_driver: time-multiplexed 4-digit 7-segment scan driver.
//
// Scans one shared segment bus across four digits, dwelling SCAN_COUNT cycles
// per digit. Display words are written into a shadow buffer and committed to
// the active buffer only at frame end (digit 3 terminal count), so a frame
// never shows a mix of old and new data.
//
// Optional feature macro: DD_BLANK_EN
//   When defined, ddGate is held at 4'b0000 for the last BLANK_CYCLES cycles
//   of every slot (anti-ghosting dead time). ddOut is still driven.
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   asynchronous reset, active-high
//   ddIn       in   32  display word; digit0=[31:24] .. digit3=[7:0]
//   ddWrEn     in   1   write strobe; captures ddIn into the shadow buffer
//   ddOut      out  8   segment pattern of the digit currently gated
//   ddGate     out  4   one-hot digit enable; bit i selects digit i
//   ddPending  out  1   shadow holds a word not yet committed
//   frameDone  out  1   1-cycle pulse after digit 3's slot ends

module dd_scan_driver #(
    parameter int unsigned            COUNT_WIDTH  = 28,
    parameter logic [COUNT_WIDTH-1:0] SCAN_COUNT   = COUNT_WIDTH'(28'h3000),
    parameter int unsigned            BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ddIn,
    input  logic        ddWrEn,
    output logic [7:0]  ddOut,
    output logic [3:0]  ddGate,
    output logic        ddPending,
    output logic        frameDone
);

    localparam logic [COUNT_WIDTH-1:0] TcValue = SCAN_COUNT - COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]             digit_q, digit_d;
    logic [31:0]            active_q, active_d;
    logic [31:0]            shadow_q, shadow_d;
    logic                   pending_q, pending_d;
    logic [7:0]             out_q, out_d;
    logic [3:0]             gate_q, gate_d;
    logic                   frame_done_q, frame_done_d;

    logic tc;
    logic frame_end;
    logic blank;

    assign tc        = (cnt_q == TcValue);
    assign frame_end = tc && (digit_q == 2'd3);

`ifdef DD_BLANK_EN
    localparam logic [COUNT_WIDTH-1:0] BlankStart = SCAN_COUNT - COUNT_WIDTH'(BLANK_CYCLES);
    assign blank = (cnt_q >= BlankStart);
`else
    logic unused_blank_cycles;
    assign unused_blank_cycles = ^BLANK_CYCLES;
    assign blank               = 1'b0;
`endif

    always_comb begin
        cnt_d        = cnt_q + COUNT_WIDTH'(1);
        digit_d      = digit_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        out_d        = 8'h00;
        gate_d       = 4'b0000;
        frame_done_d = frame_end;

        if (tc) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
        end

        // Commit uses the pre-write shadow; a colliding write stays pending
        // and lands at the following frame end.
        if (frame_end && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        if (ddWrEn) begin
            shadow_d  = ddIn;
            pending_d = 1'b1;
        end

        unique case (digit_q)
            2'd0: out_d = active_q[31:24];
            2'd1: out_d = active_q[23:16];
            2'd2: out_d = active_q[15:8];
            2'd3: out_d = active_q[7:0];
            default: out_d = 8'h00;
        endcase

        if (!blank) begin
            gate_d = 4'b0001 << digit_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            active_q     <= 32'h0;
            shadow_q     <= 32'h0;
            pending_q    <= 1'b0;
            out_q        <= 8'h00;
            gate_q       <= 4'b0000;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            out_q        <= out_d;
            gate_q       <= gate_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ddOut     = out_q;
    assign ddGate    = gate_q;
    assign ddPending = pending_q;
    assign frameDone = frame_done_q;

endmodule
